// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/valid fetches and fills the IF/ID register.
// Handles hazard stalls with a one-entry skid buffer and flushes on branch/jump redirects.
module fetch_stage #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [31:0]     if_id_inst,
    output logic [PC_W-1:0] if_id_pc,
    output logic [PC_W-1:0] if_id_pc_plus4,
    output logic [5:0]      id_opcode
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned OP_W   = 6;
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus4;
    } if_id_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic              req_q, req_d;
    if_id_t            ifid_q, ifid_d;
    logic [INST_W-1:0] buf_inst_q, buf_inst_d;
    logic [PC_W-1:0]   buf_pc_q, buf_pc_d;
    logic              done;
    logic [PC_W-1:0]   redirect_tgt;

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC_A;
            addr_q     <= RESET_PC_A;
            req_q      <= 1'b0;
            ifid_q     <= '0;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            ifid_q     <= ifid_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    // Next-state and next-output logic; redirect outranks stall and completion
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_d       = ifid_q;
        buf_inst_d   = buf_inst_q;
        buf_pc_d     = buf_pc_q;
        done         = req_q & imem_valid;
        redirect_tgt = redirect_pc & ALIGN_MASK;

        if (redirect_valid) begin
            pc_d         = redirect_tgt;
            ifid_d.valid = 1'b0;
            ifid_d.inst  = '0;
            buf_inst_d   = '0;
            buf_pc_d     = '0;
            unique case (state_q)
                S_WAIT:  state_d = done ? S_WAIT : S_DROP;
                S_DROP:  state_d = S_DROP;
                default: state_d = S_WAIT;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (done && stall) begin
                        buf_inst_d = imem_rdata;
                        buf_pc_d   = pc_q;
                        state_d    = S_HOLD;
                    end else if (done) begin
                        ifid_d = '{valid: 1'b1, inst: imem_rdata, pc: pc_q,
                                   pc_plus4: pc_q + PC_W'(4)};
                        pc_d   = pc_q + PC_W'(4);
                    end else if (!stall) begin
                        ifid_d.valid = 1'b0;
                        ifid_d.inst  = '0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_d = '{valid: 1'b1, inst: buf_inst_q, pc: buf_pc_q,
                                   pc_plus4: buf_pc_q + PC_W'(4)};
                        pc_d    = buf_pc_q + PC_W'(4);
                        state_d = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (!stall) begin
                        ifid_d.valid = 1'b0;
                        ifid_d.inst  = '0;
                    end
                    if (done) state_d = S_WAIT;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A pending DROP request keeps its original address until it completes
        addr_d = (state_d == S_DROP) ? addr_q : pc_d;
        req_d  = (state_d == S_WAIT) || (state_d == S_DROP);
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign if_id_valid    = ifid_q.valid;
    assign if_id_inst     = ifid_q.inst;
    assign if_id_pc       = ifid_q.pc;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign id_opcode      = ifid_q.inst[INST_W-1 -: OP_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, and random
// stimulus against a transaction-level fetch model with a variable-latency memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [5:0]  id_opcode;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 0;
    int mode = 0;
    int wcnt;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .id_opcode      (id_opcode)
    );

    always #5 clk = ~clk;

    // Instruction contents as a function of address
    function automatic logic [31:0] memf(input logic [31:0] a, input int md);
        if (md == 0) return a;
        if (md == 1) return 32'h8C22_0004;
        return 32'(a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory: answers once a request has waited `lat` cycles (lat=0 is same-cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       wcnt <= 0;
        else if (imem_req && imem_valid)  wcnt <= 0;
        else if (imem_req)                wcnt <= wcnt + 1;
    end
    assign imem_valid = imem_req && (wcnt >= lat);
    assign imem_rdata = memf(imem_addr, mode);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: outstanding request, doomed flag, stall buffer, IF/ID contents
    bit          m_start, m_req, m_drop, m_held, m_iv;
    logic [31:0] m_pc, m_addr, m_binst, m_bpc, m_inst, m_ipc;
    int          m_wcnt;

    task automatic model_reset();
        m_start = 0; m_req = 0; m_drop = 0; m_held = 0; m_iv = 0;
        m_pc = 32'h0; m_addr = 32'h0; m_binst = 32'h0; m_bpc = 32'h0;
        m_inst = 32'h0; m_ipc = 32'h0; m_wcnt = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] p);
        bit          comp;
        logic [31:0] data;
        comp = m_req && (m_wcnt >= lat);
        data = memf(m_addr, mode);
        if (r) begin
            m_iv = 0; m_inst = 32'h0; m_held = 0; m_start = 1;
            m_pc = {p[31:2], 2'b00};
            if (m_req && (!comp || m_drop)) begin
                m_drop = 1;
                if (comp) m_wcnt = 0; else m_wcnt++;
            end else begin
                m_drop = 0; m_req = 1; m_addr = m_pc; m_wcnt = 0;
            end
        end else if (!m_start) begin
            m_start = 1; m_req = 1; m_addr = m_pc; m_wcnt = 0;
        end else if (m_held) begin
            if (!s) begin
                m_iv = 1; m_inst = m_binst; m_ipc = m_bpc; m_pc = m_bpc + 32'd4;
                m_held = 0; m_req = 1; m_addr = m_pc; m_wcnt = 0;
            end
        end else if (comp && !m_drop && s) begin
            m_held = 1; m_binst = data; m_bpc = m_addr; m_req = 0;
        end else if (comp && !m_drop) begin
            m_iv = 1; m_inst = data; m_ipc = m_addr; m_pc = m_addr + 32'd4;
            m_addr = m_pc; m_wcnt = 0;
        end else begin
            if (!s) begin m_iv = 0; m_inst = 32'h0; end
            if (comp) begin m_drop = 0; m_addr = m_pc; m_wcnt = 0; end
            else m_wcnt++;
        end
    endtask

    task automatic check_model();
        chk("model_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("model_addr", imem_addr, m_addr);
        chk("model_valid", 32'(if_id_valid), 32'(m_iv));
        chk("model_inst", if_id_inst, m_inst);
        chk("model_opcode", 32'(id_opcode), 32'(m_inst[31:26]));
        if (m_iv) begin
            chk("model_pc", if_id_pc, m_ipc);
            chk("model_pc4", if_id_pc_plus4, m_ipc + 32'd4);
        end
    endtask

    task automatic cycle(input bit s, input bit r, input logic [31:0] p);
        stall = s; redirect_valid = r; redirect_pc = p;
        model_step(s, r, p);
        @(posedge clk); #1;
        cyc++;
        check_model();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_opcode", 32'(id_opcode), 32'h0);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          do_rst;
        bit          s;
        bit          r;
        logic [31:0] p;
        int          l;
        int          md;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
    } vec_t;

    function automatic vec_t mk(bit rs, bit s, bit r, logic [31:0] p, int l, int md,
                                bit er, logic [31:0] ea, bit ev, logic [31:0] ei,
                                logic [31:0] ep4);
        vec_t v;
        v.do_rst = rs; v.s = s; v.r = r; v.p = p; v.l = l; v.md = md;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc4 = ep4;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        logic [31:0] ei;
        clk = 1'b0; rst_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();

        // Zero-latency streaming, data = address
        vq.push_back(mk(1,0,0,32'h0,0,0, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h4,  1,32'h0,32'h4));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h8,  1,32'h4,32'h8));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'hC,  1,32'h8,32'hC));
        // Slow memory returning lw
        vq.push_back(mk(1,0,0,32'h0,2,1, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,2,1, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,2,1, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,2,1, 1,32'h4,  1,32'h8C22_0004,32'h4));
        // Four-cycle stall starting on a completing cycle
        vq.push_back(mk(1,0,0,32'h0,0,0, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h4,  1,32'h0,32'h4));
        vq.push_back(mk(0,1,0,32'h0,0,0, 0,32'h0,  1,32'h0,32'h4));
        vq.push_back(mk(0,1,0,32'h0,0,0, 0,32'h0,  1,32'h0,32'h4));
        vq.push_back(mk(0,1,0,32'h0,0,0, 0,32'h0,  1,32'h0,32'h4));
        vq.push_back(mk(0,1,0,32'h0,0,0, 0,32'h0,  1,32'h0,32'h4));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h8,  1,32'h4,32'h8));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'hC,  1,32'h8,32'hC));
        // Redirect while a slow request at 0x10 is outstanding
        vq.push_back(mk(1,0,0,32'h0,0,0, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h4,  1,32'h0,32'h4));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h8,  1,32'h4,32'h8));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'hC,  1,32'h8,32'hC));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h10, 1,32'hC,32'h10));
        vq.push_back(mk(0,0,0,32'h0,2,0, 1,32'h10, 0,32'h0,32'h0));
        vq.push_back(mk(0,0,1,32'h103,2,0, 1,32'h10, 0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,2,0, 1,32'h100,0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h104,1,32'h100,32'h104));
        // Redirect together with stall while holding
        vq.push_back(mk(1,0,0,32'h0,0,0, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h4,  1,32'h0,32'h4));
        vq.push_back(mk(0,1,0,32'h0,0,0, 0,32'h0,  1,32'h0,32'h4));
        vq.push_back(mk(0,1,1,32'h200,0,0, 1,32'h200,0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h204,1,32'h200,32'h204));
        // PC wrap at the top of the address space
        vq.push_back(mk(1,0,0,32'h0,0,0, 1,32'h0,  0,32'h0,32'h0));
        vq.push_back(mk(0,0,1,32'hFFFF_FFFF,0,0, 1,32'hFFFF_FFFC,0,32'h0,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h0,  1,32'hFFFF_FFFC,32'h0));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h4,  1,32'h0,32'h4));
        vq.push_back(mk(0,0,0,32'h0,0,0, 1,32'h8,  1,32'h4,32'h8));

        foreach (vq[i]) begin
            mode = vq[i].md;
            if (vq[i].do_rst) do_reset();
            lat = vq[i].l;
            cycle(vq[i].s, vq[i].r, vq[i].p);
            ei = vq[i].e_inst;
            chk("vec_req", 32'(imem_req), 32'(vq[i].e_req));
            if (vq[i].e_req) chk("vec_addr", imem_addr, vq[i].e_addr);
            chk("vec_valid", 32'(if_id_valid), 32'(vq[i].e_valid));
            chk("vec_inst", if_id_inst, ei);
            chk("vec_opcode", 32'(id_opcode), 32'(ei[31:26]));
            if (vq[i].e_valid) begin
                chk("vec_pc4", if_id_pc_plus4, vq[i].e_pc4);
                chk("vec_pc", if_id_pc, vq[i].e_pc4 - 32'd4);
            end
        end

        // Async reset in the middle of a pending, stalled request
        lat = 5;
        cycle(1'b1, 1'b0, 32'h0);
        chk("prerst_req", 32'(imem_req), 32'h1);
        chk("prerst_valid", 32'(if_id_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_valid", 32'(if_id_valid), 32'h0);
        chk("async_inst", if_id_inst, 32'h0);
        stall = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        chk("postrst_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("postrst_inst", if_id_inst, 32'h0);
        chk("postrst_valid", 32'(if_id_valid), 32'h1);

        // Randomized traffic against the model
        mode = 2;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          s, r;
            logic [31:0] p;
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
            cycle(s, r, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
